// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: operand handshake in,
// result handshake out, plus the busy status flag.
interface seq_shifter_if #(
  parameter int WIDTH = 8,
  parameter int NW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [NW-1:0]    n;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  in_valid, a, n, dir, mode, out_ready,
    output in_ready, y, out_valid, busy
  );

  modport master (
    output in_valid, a, n, dir, mode, out_ready,
    input  in_ready, y, out_valid, busy
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: logical / arithmetic / rotate, at most STEP
// positions per clock, one request in flight.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a request, in_ready high
// SHIFT   | shifting work register, remaining > 0
// DONE    | result held on y with out_valid until taken
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int NW    = 4,
  parameter int STEP  = 1
) (
  input  logic         clk,
  input  logic         rst,
  seq_shifter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_ARITH = 2'b01;
  localparam logic [1:0] M_ROT   = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [NW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             sign_q, sign_d;

  logic [31:0]      n_ext;
  logic [31:0]      eff_full;
  logic [NW-1:0]    eff;
  logic [NW-1:0]    k;
  logic [WIDTH-1:0] shifted;

  // Effective count: rotate wraps, other modes saturate at WIDTH.
  always_comb begin
    n_ext = 32'(bus.n);
    if (bus.mode == M_ROT) begin
      eff_full = n_ext % 32'(WIDTH);
    end else if (n_ext > 32'(WIDTH)) begin
      eff_full = 32'(WIDTH);
    end else begin
      eff_full = n_ext;
    end
    eff = NW'(eff_full);
  end

  // Step size this cycle, then a small mux over the STEP constant shifts
  // instead of a full barrel network.
  always_comb begin
    k       = (32'(rem_q) < 32'(STEP)) ? rem_q : NW'(STEP);
    shifted = work_q;
    for (int i = 1; i <= STEP; i++) begin
      if (32'(k) == 32'(i)) begin
        if (dir_q) begin
          if (mode_q == M_ROT) shifted = (work_q << i) | (work_q >> (WIDTH - i));
          else                 shifted = work_q << i;
        end else if (mode_q == M_ROT) begin
          shifted = (work_q >> i) | (work_q << (WIDTH - i));
        end else if (mode_q == M_ARITH && sign_q) begin
          shifted = (work_q >> i) | ~({WIDTH{1'b1}} >> i);
        end else begin
          shifted = work_q >> i;
        end
      end
    end
  end

  // Next-state logic for the sequencer and datapath registers.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.a;
          dir_d   = bus.dir;
          mode_d  = bus.mode;
          sign_d  = bus.a[WIDTH-1];
          rem_d   = eff;
          state_d = (eff != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - k;
        if (rem_q == k) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.y         = work_q;

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle, parametrised shifter that extends the team's 8-bit combinational left/right shifter. It adds:
- configurable data width and bits-per-cycle shift step;
- logical, arithmetic and rotate modes;
- valid/ready handshakes on both sides.

It sits between a register-file read port and the writeback mux. It trades latency for area: at most STEP positions are shifted per clock instead of using a full barrel network.

## Interface
- WIDTH, 8, data width in bits; at least 2.
- NW, 4, width of the shift-amount port; 2^NW must exceed WIDTH.
- STEP, 1, maximum positions shifted per cycle; a power of two, 1 ≤ STEP ≤ WIDTH.

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request (high only in IDLE)
- a  in  WIDTH  operand
- n  in  NW  requested shift amount
- dir  in  1  0 = shift right, 1 = shift left
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (behaves as logical)
- y  out  WIDTH  result; valid only while out_valid = 1
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- busy  out  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready = 1.
  - Accept happens on a rising edge with in_valid & in_ready.
  - On accept, capture into the work register, and capture dir, mode and sign = a[WIDTH-1].
  - Compute the effective count eff:
    - rotate: eff = n mod WIDTH;
    - otherwise: eff = min(n, WIDTH).
  - Load remaining = eff. Next state is SHIFT if eff > 0, else DONE.
- SHIFT: each edge shifts the work register by k = min(STEP, remaining), then remaining -= k. When remaining reaches 0, next state is DONE. in_ready = 0.
- Fill rules:
  - logical: zeros enter.
  - arithmetic right: the captured sign enters.
  - arithmetic left: identical to logical left.
  - rotate: bits leaving one end enter the other.
  - reserved mode 11: identical to logical.
- DONE: out_valid = 1 and y = work register, both held stable. On an edge with out_ready = 1, next state is IDLE. in_valid is ignored.
- n ≥ WIDTH:
  - logical result is all zeros;
  - arithmetic right result is all sign bits;
  - rotate wraps modulo WIDTH.
  The cycle count follows eff.
- y during IDLE and SHIFT is undefined for consumers. Implementation drives it from the work register.
- No accept in DONE: one request in flight, no overlap.

## Timing
- Reset: on any edge with rst = 1, the block goes to IDLE.
  - Next-cycle values: out_valid = 0, busy = 0, in_ready = 1, y = 0, remaining = 0.
  - rst overrides in_valid and out_ready on the same edge.
  - Reset in SHIFT or DONE discards the request; no partial result is ever flagged valid.
- Latency: if accept is at edge E0, out_valid rises after edge E0 + ceil(eff/STEP).
  - eff = 0 gives out_valid in the cycle immediately after E0.
  - Worst case is E0 + ceil(WIDTH/STEP).
- Return to IDLE: one edge after out_ready is sampled high in DONE. in_ready is high the following cycle. Minimum request spacing is ceil(eff/STEP) + 2 cycles.
- in_valid is sampled only in IDLE. It may be held or changed freely in other states.
- busy = (state != IDLE), decoded from registered state with no combinational input path. in_ready is likewise a pure state decode.

## Test plan
Default parameters (WIDTH=8, NW=4, STEP=1) with a = 8'b1000_0001 unless stated otherwise.

1. Logical right, n=3, dir=0, mode=00 -> y=8'b0001_0000; out_valid high exactly 3 edges after accept; busy high from the accept edge.
2. Arithmetic: right n=3 -> 8'b1111_0000; arithmetic left n=3 -> 8'b0000_1000.
3. Rotate:
   - left n=3 -> 8'b0000_1100;
   - right n=11 (eff 3) -> 8'b0011_0000 after 3 cycles;
   - right n=8 -> 8'b1000_0001 with out_valid the cycle after accept.
4. Boundaries:
   - n=15 logical right -> 8'b0000_0000 after 8 cycles;
   - n=15 arithmetic right -> 8'b1111_1111 after 8 cycles;
   - n=0 -> y = a in the cycle after accept;
   - sweep n=0..8 in both directions against a software model.
5. Backpressure:
   - hold out_ready=0 for 5 cycles in DONE -> y and out_valid stable, in_ready=0, a pulsed in_valid ignored;
   - then raise out_ready -> in_ready=1 two cycles later.
6. Reset and STEP:
   - rst pulse during SHIFT -> next cycle out_valid=0, y=0, in_ready=1;
   - a STEP=4 instance with n=7 logical left -> y=8'b1000_0000 after exactly 2 shift cycles.
